flags_unit: RTL and testbench
=============================

# flags_unit

Condition-flag producer for the execute/branch boundary of the pipeline. Derives zero, negative and carry from each valid ALU result under a per-flag update mask and holds them in a flag register. Supports explicit set/clear of carry and clears the tested flag after a taken conditional jump. Drives the `z`, `n`, `c` inputs of the branch-decision logic, with an optional save/restore stack for interrupt entry and return.

## Interface
Parameters:
- `WIDTH`, 32, ALU result width.
- `STACK_DEPTH`, 2, number of saved flag sets for nested interrupts (≥1; only meaningful with the stack compiled in).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `enable`  in  1  stage enable; 0 freezes all state, including the stack pointer.
- `alu_valid`  in  1  `alu_result`/`alu_carry` are valid this cycle.
- `alu_result`  in  WIDTH  ALU output.
- `alu_carry`  in  1  ALU carry-out.
- `flag_mask`  in  3  per-flag update enables from the ALU op, ordered {c,n,z}.
- `setc`  in  1  set-carry instruction.
- `clrc`  in  1  clear-carry instruction.
- `branch`  in  3  branch code of the instruction resolving this cycle (100 JMP, 101 JZ, 110 JN, 111 JC, others none).
- `jump_taken`  in  1  the branch was taken this cycle.
- `int_save`  in  1  interrupt entry: push current flags.
- `int_restore`  in  1  interrupt return: pop flags.
- `z`, `n`, `c`  out  1 each  registered flags.
- `stack_ovf`  out  1  sticky: a push arrived while the stack was full.
- `stack_unf`  out  1  sticky: a pop arrived while the stack was empty.

## Operation
- Reset: `z`=`n`=`c`=0; stack empty (pointer 0); `stack_ovf`=`stack_unf`=0.
- `enable`=0: hold everything; all other inputs are ignored.
- ALU-derived values:
  - z_alu = (`alu_result` == 0).
  - n_alu = `alu_result[WIDTH-1]`.
  - c_alu = `alu_carry`.
- Per-flag next state, highest priority first:
  1. Pop: `int_restore` with stack non-empty loads all three flags from the top entry.
  2. ALU update: `alu_valid` with the flag's mask bit set loads the ALU-derived value.
  3. Carry only: `setc` → 1, else `clrc` → 0. `setc` and `clrc` together gives 1.
  4. Jump clear: `jump_taken` with JZ/JN/JC clears z/n/c respectively. JMP and other codes clear nothing.
  5. Otherwise the flag holds.
- Stack (LIFO, depth `STACK_DEPTH`):
  - Push: `int_save` writes the current registered flags, pre-update, and increments the pointer.
  - Push when full: discarded; sets `stack_ovf`.
  - Pop when empty: flags unchanged; sets `stack_unf`.
  - `int_save` and `int_restore` in the same cycle: the restore is performed and the save is ignored. No overflow is flagged.
  - Sticky flags clear only on reset.
- Reset asserted mid-operation: all state returns to reset values immediately. Stack contents are don't-care, but the pointer is 0.

## Timing
- Outputs are purely registered; there is no combinational path from any input to `z`/`n`/`c`.
- Latency: flags reflect an ALU result 1 cycle after `alu_valid`, i.e. visible to a branch resolving the next cycle.
- Jump clear, set/clear carry, push and pop all take effect at the next edge.
- `stack_ovf`/`stack_unf` assert 1 cycle after the offending request.

## Configuration
- `FLAGS_STACK_EN` defined: the save/restore stack, `stack_ovf` and `stack_unf` are implemented as above.
- `FLAGS_STACK_EN` undefined:
  - No stack storage.
  - `int_save` and `int_restore` are ignored; rule 1 never applies.
  - `stack_ovf` and `stack_unf` are tied to 0.

## Test plan
- Reset, then `alu_valid`=1, `alu_result`=0, `alu_carry`=1, `flag_mask`=111 → next cycle z=1, n=0, c=1. Repeat with `alu_result`=0x80000000, `flag_mask`=010 → z=1, n=1, c=1.
- With z=1: `branch`=101, `jump_taken`=1 → z=0. Same cycle plus `alu_valid` with result 0 and mask 001 → z=1 (ALU wins over jump clear).
- c=0: `setc` → c=1; `clrc` → c=0; `setc`+`clrc` → c=1; `setc` with `alu_valid`, `alu_carry`=0, mask 100 → c=0.
- Stack, default depth: flags 101 push, flags 010 push, third push → `stack_ovf`=1. Pop → flags 010; pop → 101; third pop → `stack_unf`=1, flags stay 101.
- `enable`=0 with `alu_valid`, `setc` and `int_save` asserted → flags, pointer and sticky bits unchanged. Assert `rst_n`=0 mid-stream → all outputs 0 without waiting for a clock edge.
- Build without `FLAGS_STACK_EN`: `int_save` then `int_restore` → flags unchanged; `stack_ovf`/`stack_unf` stay 0.

Source files
------------

// File: rtl/flags_unit.sv
// -----------------------------------------------------------------------------
// flags_unit
//
// Condition-flag register for the execute/branch boundary. Derives zero,
// negative and carry from each valid ALU result under a per-flag update mask.
// It also handles explicit set/clear of carry and clears the flag a taken
// conditional jump tested. An optional LIFO saves and restores the flags on
// interrupt entry and return.
//
// Build option:
//   FLAGS_STACK_EN  when defined, compiles in the save/restore stack and the
//                   sticky stack_ovf/stack_unf indicators. When undefined,
//                   int_save/int_restore are ignored and both indicators
//                   read 0.
//
// Parameters:
//   WIDTH        ALU result width.
//   STACK_DEPTH  number of saved flag sets (>= 1, used only with the stack).
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   enable       stage enable; 0 freezes all state
//   alu_valid    alu_result / alu_carry are valid this cycle
//   alu_result   ALU output [WIDTH-1:0]
//   alu_carry    ALU carry-out
//   flag_mask    per-flag update enables, ordered {c,n,z}
//   setc, clrc   set / clear carry (both together sets)
//   branch       branch code: 100 JMP, 101 JZ, 110 JN, 111 JC
//   jump_taken   the branch resolving this cycle was taken
//   int_save     push the current flags
//   int_restore  pop the flags
//   z, n, c      registered flags
//   stack_ovf    sticky: push while the stack was full
//   stack_unf    sticky: pop while the stack was empty
// -----------------------------------------------------------------------------
module flags_unit #(
  parameter int WIDTH       = 32,
  parameter int STACK_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             alu_valid,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry,
  input  logic [2:0]       flag_mask,
  input  logic             setc,
  input  logic             clrc,
  input  logic [2:0]       branch,
  input  logic             jump_taken,
  input  logic             int_save,
  input  logic             int_restore,
  output logic             z,
  output logic             n,
  output logic             c,
  output logic             stack_ovf,
  output logic             stack_unf
);

  localparam logic [2:0] BR_JZ = 3'b101;
  localparam logic [2:0] BR_JN = 3'b110;
  localparam logic [2:0] BR_JC = 3'b111;

  logic z_q, z_d;
  logic n_q, n_d;
  logic c_q, c_d;

  logic z_alu;
  logic n_alu;
  logic c_alu;

  // pop_ok: a restore that actually loads flags this cycle.
  // pop_flags: the top stack entry, packed {c,n,z}.
  logic       pop_ok;
  logic [2:0] pop_flags;

  assign z_alu = (alu_result == '0);
  assign n_alu = alu_result[WIDTH-1];
  assign c_alu = alu_carry;

`ifdef FLAGS_STACK_EN
  // The pointer counts 0..STACK_DEPTH inclusive, so it needs one extra code
  // beyond the entry count. The storage array is sized to the pointer's full
  // range, which lets the pointer index it directly without width mismatch.
  // Entries at or above STACK_DEPTH are never written.
  localparam int              PTR_W    = $clog2(STACK_DEPTH + 1);
  localparam int              MEM_N    = 1 << PTR_W;
  localparam logic [PTR_W-1:0] FULL_PTR = PTR_W'(STACK_DEPTH);

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             stack_ovf_q, stack_ovf_d;
  logic             stack_unf_q, stack_unf_d;
  logic [2:0]       stack_mem_q [MEM_N];
  logic             push_we;
  logic [PTR_W-1:0] top_idx;

  assign top_idx = ptr_q - PTR_W'(1);

  always_comb begin
    ptr_d       = ptr_q;
    stack_ovf_d = stack_ovf_q;
    stack_unf_d = stack_unf_q;
    push_we     = 1'b0;
    pop_ok      = 1'b0;
    pop_flags   = stack_mem_q[top_idx];
    if (enable) begin
      // When a save and a restore arrive together, the restore is performed
      // and the save is dropped silently, so no overflow is raised.
      if (int_restore) begin
        if (ptr_q == '0) begin
          stack_unf_d = 1'b1;
        end else begin
          pop_ok = 1'b1;
          ptr_d  = top_idx;
        end
      end else if (int_save) begin
        if (ptr_q == FULL_PTR) begin
          stack_ovf_d = 1'b1;
        end else begin
          push_we = 1'b1;
          ptr_d   = ptr_q + PTR_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      stack_ovf_q <= 1'b0;
      stack_unf_q <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      stack_ovf_q <= stack_ovf_d;
      stack_unf_q <= stack_unf_d;
    end
  end

  // Stack contents are not reset; only the pointer says what is live.
  // A push stores the flags as they were before this cycle's update.
  always_ff @(posedge clk) begin
    if (push_we) begin
      stack_mem_q[ptr_q] <= {c_q, n_q, z_q};
    end
  end

  assign stack_ovf = stack_ovf_q;
  assign stack_unf = stack_unf_q;
`else
  localparam int unused_stack_depth = STACK_DEPTH;
  logic unused_stack_inputs;

  assign unused_stack_inputs = int_save ^ int_restore;
  assign pop_ok              = 1'b0;
  assign pop_flags           = 3'b000;
  assign stack_ovf           = 1'b0;
  assign stack_unf           = 1'b0;
`endif

  // Per-flag priority: pop, then ALU, then set/clear carry (carry only),
  // then jump clear, then hold.
  always_comb begin
    z_d = z_q;
    n_d = n_q;
    c_d = c_q;
    if (enable) begin
      if (pop_ok) begin
        {c_d, n_d, z_d} = pop_flags;
      end else begin
        if (alu_valid && flag_mask[0]) begin
          z_d = z_alu;
        end else if (jump_taken && (branch == BR_JZ)) begin
          z_d = 1'b0;
        end

        if (alu_valid && flag_mask[1]) begin
          n_d = n_alu;
        end else if (jump_taken && (branch == BR_JN)) begin
          n_d = 1'b0;
        end

        if (alu_valid && flag_mask[2]) begin
          c_d = c_alu;
        end else if (setc) begin
          c_d = 1'b1;
        end else if (clrc) begin
          c_d = 1'b0;
        end else if (jump_taken && (branch == BR_JC)) begin
          c_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_q <= 1'b0;
      n_q <= 1'b0;
      c_q <= 1'b0;
    end else begin
      z_q <= z_d;
      n_q <= n_d;
      c_q <= c_d;
    end
  end

  assign z = z_q;
  assign n = n_q;
  assign c = c_q;

endmodule

// File: tb/tb_flags_unit.sv
// -----------------------------------------------------------------------------
// tb_flags_unit
//
// Self-checking bench for flags_unit at default parameters. A queue-based
// behavioural model tracks the expected flags, stack and sticky bits. A
// negedge process compares every output against it each cycle. Directed steps
// pin both the DUT and the model to hand-computed values, and a randomized
// phase follows. Stack-specific steps are selected by FLAGS_STACK_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_flags_unit;

  localparam int WIDTH = 32;
  localparam int DEPTH = 2;
`ifdef FLAGS_STACK_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             enable;
  logic             alu_valid;
  logic [WIDTH-1:0] alu_result;
  logic             alu_carry;
  logic [2:0]       flag_mask;
  logic             setc;
  logic             clrc;
  logic [2:0]       branch;
  logic             jump_taken;
  logic             int_save;
  logic             int_restore;
  logic             z, n, c, stack_ovf, stack_unf;

  always #5 clk = ~clk;

  flags_unit #(.WIDTH(WIDTH), .STACK_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .alu_valid(alu_valid),
    .alu_result(alu_result), .alu_carry(alu_carry), .flag_mask(flag_mask),
    .setc(setc), .clrc(clrc), .branch(branch), .jump_taken(jump_taken),
    .int_save(int_save), .int_restore(int_restore),
    .z(z), .n(n), .c(c), .stack_ovf(stack_ovf), .stack_unf(stack_unf)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Behavioural model state
  logic       mz, mn, mc, movf, munf;
  logic [2:0] mstk[$];   // entries packed {c,n,z}

  task automatic check(input string name, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin : model
    logic       nz, nn, nc;
    logic [2:0] top;
    bit         popped;
    if (!rst_n) begin
      mz = 1'b0; mn = 1'b0; mc = 1'b0; movf = 1'b0; munf = 1'b0;
      mstk.delete();
    end else if (enable) begin
      nz = mz; nn = mn; nc = mc; popped = 1'b0; top = 3'b000;
      if (STK) begin
        if (int_restore) begin
          if (mstk.size() == 0) munf = 1'b1;
          else begin
            top = mstk.pop_back();
            popped = 1'b1;
          end
        end else if (int_save) begin
          if (mstk.size() >= DEPTH) movf = 1'b1;
          else mstk.push_back({mc, mn, mz});
        end
      end
      if (popped) begin
        nc = top[2]; nn = top[1]; nz = top[0];
      end else begin
        if (alu_valid && flag_mask[0]) nz = (alu_result == 0);
        else if (jump_taken && branch == 3'b101) nz = 1'b0;
        if (alu_valid && flag_mask[1]) nn = alu_result[WIDTH-1];
        else if (jump_taken && branch == 3'b110) nn = 1'b0;
        if (alu_valid && flag_mask[2]) nc = alu_carry;
        else if (setc) nc = 1'b1;
        else if (clrc) nc = 1'b0;
        else if (jump_taken && branch == 3'b111) nc = 1'b0;
      end
      mz = nz; mn = nn; mc = nc;
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      check("cyc_z", z, mz);
      check("cyc_n", n, mn);
      check("cyc_c", c, mc);
      check("cyc_ovf", stack_ovf, movf);
      check("cyc_unf", stack_unf, munf);
    end
  end

  task automatic idle();
    enable = 1'b1; alu_valid = 1'b0; alu_result = '0; alu_carry = 1'b0;
    flag_mask = 3'b000; setc = 1'b0; clrc = 1'b0; branch = 3'b000;
    jump_taken = 1'b0; int_save = 1'b0; int_restore = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic expect3(input string nm, input logic ez, input logic en, input logic ec);
    check({nm, "_z"}, z, ez);
    check({nm, "_n"}, n, en);
    check({nm, "_c"}, c, ec);
    check({nm, "_model_z"}, mz, ez);
    check({nm, "_model_n"}, mn, en);
    check({nm, "_model_c"}, mc, ec);
  endtask

  task automatic expect_sticky(input string nm, input logic eo, input logic eu);
    check({nm, "_ovf"}, stack_ovf, eo);
    check({nm, "_unf"}, stack_unf, eu);
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    expect3("reset", 1'b0, 1'b0, 1'b0);
    expect_sticky("reset", 1'b0, 1'b0);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    idle(); alu_valid = 1'b1; alu_result = '0; alu_carry = 1'b1; flag_mask = 3'b111;
    tick(); expect3("alu_zero", 1'b1, 1'b0, 1'b1);
    idle(); alu_valid = 1'b1; alu_result = 32'h8000_0000; flag_mask = 3'b010;
    tick(); expect3("alu_neg_masked", 1'b1, 1'b1, 1'b1);
    idle(); branch = 3'b101; jump_taken = 1'b1;
    tick(); expect3("jz_clear", 1'b0, 1'b1, 1'b1);
    idle(); branch = 3'b101; jump_taken = 1'b1; alu_valid = 1'b1; alu_result = '0; flag_mask = 3'b001;
    tick(); expect3("alu_over_jz", 1'b1, 1'b1, 1'b1);
    idle(); branch = 3'b100; jump_taken = 1'b1;
    tick(); expect3("jmp_keeps", 1'b1, 1'b1, 1'b1);
    idle(); branch = 3'b110; jump_taken = 1'b0;
    tick(); expect3("jn_not_taken", 1'b1, 1'b1, 1'b1);
    idle(); branch = 3'b110; jump_taken = 1'b1;
    tick(); expect3("jn_clear", 1'b1, 1'b0, 1'b1);
    idle(); branch = 3'b111; jump_taken = 1'b1;
    tick(); expect3("jc_clear", 1'b1, 1'b0, 1'b0);
    idle(); setc = 1'b1;
    tick(); expect3("setc", 1'b1, 1'b0, 1'b1);
    idle(); clrc = 1'b1;
    tick(); expect3("clrc", 1'b1, 1'b0, 1'b0);
    idle(); setc = 1'b1; clrc = 1'b1;
    tick(); expect3("setc_clrc", 1'b1, 1'b0, 1'b1);
    idle(); setc = 1'b1; alu_valid = 1'b1; alu_result = 32'h1; alu_carry = 1'b0; flag_mask = 3'b100;
    tick(); expect3("alu_over_setc", 1'b1, 1'b0, 1'b0);
    idle(); setc = 1'b1; branch = 3'b111; jump_taken = 1'b1;
    tick(); expect3("setc_over_jc", 1'b1, 1'b0, 1'b1);

    idle(); enable = 1'b0; alu_valid = 1'b1; alu_result = 32'h5; alu_carry = 1'b0;
    flag_mask = 3'b111; setc = 1'b1; int_save = 1'b1;
    tick(); expect3("disabled", 1'b1, 1'b0, 1'b1);
    expect_sticky("disabled", 1'b0, 1'b0);

`ifdef FLAGS_STACK_EN
    // Push 101 and change flags to 010 in the same cycle (push sees pre-update)
    idle(); int_save = 1'b1; alu_valid = 1'b1; alu_result = 32'h8000_0001; alu_carry = 1'b0; flag_mask = 3'b111;
    tick(); expect3("push1", 1'b0, 1'b1, 1'b0);
    expect_sticky("push1", 1'b0, 1'b0);
    idle(); int_save = 1'b1;
    tick(); expect_sticky("push2", 1'b0, 1'b0);
    idle(); int_save = 1'b1;
    tick(); expect_sticky("push3_full", 1'b1, 1'b0);
    idle(); alu_valid = 1'b1; alu_result = 32'h5; alu_carry = 1'b1; flag_mask = 3'b111;
    tick(); expect3("scramble", 1'b0, 1'b0, 1'b1);
    idle(); int_restore = 1'b1; alu_valid = 1'b1; alu_result = '0; alu_carry = 1'b1; flag_mask = 3'b111;
    tick(); expect3("pop1", 1'b0, 1'b1, 1'b0);
    idle(); int_restore = 1'b1;
    tick(); expect3("pop2", 1'b1, 1'b0, 1'b1);
    expect_sticky("pop2", 1'b1, 1'b0);
    idle(); int_restore = 1'b1;
    tick(); expect3("pop3_empty", 1'b1, 1'b0, 1'b1);
    expect_sticky("pop3_empty", 1'b1, 1'b1);
`else
    idle(); int_save = 1'b1;
    tick(); expect3("nostk_save", 1'b1, 1'b0, 1'b1);
    idle(); alu_valid = 1'b1; alu_result = 32'h7; alu_carry = 1'b0; flag_mask = 3'b111;
    tick(); expect3("nostk_alu", 1'b0, 1'b0, 1'b0);
    idle(); int_restore = 1'b1;
    tick(); expect3("nostk_restore", 1'b0, 1'b0, 1'b0);
    expect_sticky("nostk", 1'b0, 1'b0);
    idle(); alu_valid = 1'b1; alu_result = '0; alu_carry = 1'b1; flag_mask = 3'b101;
    tick(); expect3("nostk_set", 1'b1, 1'b0, 1'b1);
`endif

    // Asynchronous reset in mid-cycle: outputs clear without a clock edge
    idle();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    expect3("async_rst", 1'b0, 1'b0, 1'b0);
    expect_sticky("async_rst", 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized phase
    for (int i = 0; i < 3000; i++) begin
      enable     = ($urandom_range(0, 9) != 0);
      alu_valid  = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: alu_result = '0;
        1: alu_result = 32'h8000_0000 | $urandom;
        2: alu_result = $urandom;
        default: alu_result = $urandom_range(0, 3);
      endcase
      alu_carry   = 1'($urandom_range(0, 1));
      flag_mask   = 3'($urandom_range(0, 7));
      setc        = ($urandom_range(0, 3) == 0);
      clrc        = ($urandom_range(0, 3) == 0);
      branch      = 3'($urandom_range(0, 7));
      jump_taken  = 1'($urandom_range(0, 1));
      int_save    = ($urandom_range(0, 3) == 0);
      int_restore = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 399) == 0) begin
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
      tick();
    end

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
